// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : alu_pkg                                                        |
// | Purpose   : Shared constants and types for the ALU issue stage: ALU        |
// |             control codes, RV64 opcode/funct constants and the buffer      |
// |             entry type that holds one {a, b, ctrl, illegal} triple.        |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package alu_pkg;

  // ALU control codes consumed by the execute ALU
  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  // Major opcodes handled by the issue decoder
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // funct7 values: base integer ops and the alternate (SUB) encoding
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // funct3 values
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // Entry operands are sized for the 64-bit ALU; narrower XLEN builds
  // zero-extend into the entry and slice back out.
  localparam int unsigned ENTRY_W = 64;

  typedef struct packed {
    logic [ENTRY_W-1:0] a;
    logic [ENTRY_W-1:0] b;
    logic [1:0]         ctrl;
    logic               illegal;
  } alu_issue_t;

  // Value held by the buffer registers out of reset
  localparam alu_issue_t ENTRY_RESET = '{a: '0, b: '0, ctrl: ALU_ADD, illegal: 1'b0};

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : alu_op_decode                                                  |
// | Purpose   : Combinational decode of a raw RV64 instruction word into the   |
// |             2-bit ALU control code, the operand-B select and an illegal    |
// |             flag. Illegal encodings report ctrl = ADD, use_imm = 0.        |
// | Ports     : instr   (in, 32)  raw instruction word                         |
// |             ctrl    (out, 2)  ALU control code                             |
// |             use_imm (out, 1)  1: operand B is the immediate, 0: rs2        |
// |             illegal (out, 1)  encoding not supported by this stage         |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [1:0]  ctrl,
  output logic        use_imm,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Register specifiers are resolved upstream; only the op fields matter here.
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    ctrl    = ALU_ADD;
    use_imm = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD:  ctrl = ALU_ADD;
            F3_AND:  ctrl = ALU_AND;
            F3_OR:   ctrl = ALU_OR;
            default: illegal = 1'b1;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          ctrl = ALU_SUB;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_I: begin
        case (funct3)
          F3_ADD: begin
            ctrl    = ALU_ADD;
            use_imm = 1'b1;
          end
          F3_AND: begin
            ctrl    = ALU_AND;
            use_imm = 1'b1;
          end
          F3_OR: begin
            ctrl    = ALU_OR;
            use_imm = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      // Address generation: base + offset for every width
      OP_LOAD, OP_STORE: begin
        ctrl    = ALU_ADD;
        use_imm = 1'b1;
      end
      // Equality compare is done as rs1 - rs2 and tested for zero downstream
      OP_BRANCH: begin
        if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
          ctrl = ALU_SUB;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : alu_issue                                                      |
// | Purpose   : Issue stage in front of the 64-bit execute ALU. Decodes the    |
// |             instruction, selects operand B and registers the resulting     |
// |             {ctrl, A, B} triple through a 2-entry skid buffer.             |
// | Ports     : clk, rst_n (sync, active-low), flush                           |
// |             in_valid/in_ready, in_instr[31:0], in_rs1/in_rs2/in_imm[XLEN]  |
// |             out_valid/out_ready, out_a/out_b[XLEN], out_ctrl[1:0],         |
// |             out_illegal                                                    |
// | Config    : ALU_ISSUE_ILLEGAL_TRAP_EN - when defined, illegal encodings    |
// |             are enqueued flagged (ctrl=ADD, B=0); otherwise they are       |
// |             accepted and dropped and out_illegal is tied low.              |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [1:0]      out_ctrl,
  output logic            out_illegal
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  logic [1:0] state_q, state_d;
  alu_issue_t head_q, head_d;
  alu_issue_t skid_q, skid_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;

  logic [1:0] dec_ctrl;
  logic       dec_use_imm;
  logic       dec_illegal;
  alu_issue_t new_entry;
  logic       enq;
  logic       deq;

  alu_op_decode u_decode (
    .instr   (in_instr),
    .ctrl    (dec_ctrl),
    .use_imm (dec_use_imm),
    .illegal (dec_illegal)
  );

  // Build the entry for the offered instruction. Illegal entries carry
  // ctrl = ADD (from the decoder) and B = 0.
  always_comb begin
    new_entry.a       = ENTRY_W'(in_rs1);
    new_entry.b       = dec_illegal ? '0 :
                        (dec_use_imm ? ENTRY_W'(in_imm) : ENTRY_W'(in_rs2));
    new_entry.ctrl    = dec_ctrl;
    new_entry.illegal = TRAP_EN & dec_illegal;
  end

  // An accepted illegal instruction only occupies a slot when trapping is
  // enabled; otherwise the handshake completes and the entry is dropped.
  assign enq = in_valid & in_ready_q & ~flush & (TRAP_EN | ~dec_illegal);
  assign deq = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (enq) begin
            head_d  = new_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (enq && deq) begin
            head_d = new_entry;
          end else if (enq) begin
            skid_d  = new_entry;
            state_d = ST_TWO;
          end else if (deq) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so no enqueue can coincide
          if (deq) begin
            head_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    // Handshake flags are registered from the next state so that in_ready
    // has no combinational path from out_ready.
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      head_q      <= ENTRY_RESET;
      skid_q      <= ENTRY_RESET;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_a     = head_q.a[XLEN-1:0];
  assign out_b     = head_q.b[XLEN-1:0];
  assign out_ctrl  = head_q.ctrl;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  assign out_illegal = head_q.illegal;
`else
  logic unused_illegal;
  assign unused_illegal = head_q.illegal;
  assign out_illegal    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_alu_issue                                                   |
// | Purpose   : Self-checking bench for alu_issue. A queue-based model of the  |
// |             two-slot issue buffer predicts in_ready/out_* every cycle;     |
// |             directed vectors add hand-computed literal expectations.       |
// | Config    : honours ALU_ISSUE_ILLEGAL_TRAP_EN the same way as the design.  |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_rs1;
  logic [63:0] in_rs2;
  logic [63:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_a;
  logic [63:0] out_b;
  logic [1:0]  out_ctrl;
  logic        out_illegal;

  always #5 clk = ~clk;

  alu_issue #(.XLEN(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_imm      (in_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_ctrl    (out_ctrl),
    .out_illegal (out_illegal)
  );

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  ctrl;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] imm;
  } in_t;

  localparam exp_t RESET_EXP = '{a: 64'd0, b: 64'd0, ctrl: 2'b10, ill: 1'b0};

  int n_checks = 0;
  int n_errors = 0;

  // Model state: the ordered list of entries the stage currently holds
  exp_t mq[$];
  bit   m_ready;
  exp_t m_last;
  bit   m_acc;
  bit   chk_en = 1'b0;
  in_t  pend[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // What the ALU should receive for one instruction, straight from the
  // opcode table. keep = 0 means the instruction is accepted but dropped.
  function automatic exp_t model_expect(input logic [31:0] instr, input logic [63:0] rs1,
                                        input logic [63:0] rs2, input logic [63:0] imm,
                                        output bit keep);
    exp_t       e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         legal;
    op = instr[6:0];
    f3 = instr[14:12];
    f7 = instr[31:25];
    legal = 1'b1;
    e.a   = rs1;
    e.b   = rs2;
    e.ctrl = 2'b10;
    e.ill = 1'b0;
    if      (op == 7'h33 && f3 == 3'd0 && f7 == 7'h00) e.ctrl = 2'b10;
    else if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20) e.ctrl = 2'b11;
    else if (op == 7'h33 && f3 == 3'd7 && f7 == 7'h00) e.ctrl = 2'b00;
    else if (op == 7'h33 && f3 == 3'd6 && f7 == 7'h00) e.ctrl = 2'b01;
    else if (op == 7'h13 && f3 == 3'd0) begin e.ctrl = 2'b10; e.b = imm; end
    else if (op == 7'h13 && f3 == 3'd7) begin e.ctrl = 2'b00; e.b = imm; end
    else if (op == 7'h13 && f3 == 3'd6) begin e.ctrl = 2'b01; e.b = imm; end
    else if (op == 7'h03 || op == 7'h23) begin e.ctrl = 2'b10; e.b = imm; end
    else if (op == 7'h63 && (f3 == 3'd0 || f3 == 3'd1)) e.ctrl = 2'b11;
    else legal = 1'b0;
    if (!legal) begin
      e.ctrl = 2'b10;
      e.b    = 64'd0;
      e.ill  = 1'b1;
    end
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    keep = 1'b1;
`else
    keep = legal;
`endif
    return e;
  endfunction

  // Advance the model by one rising edge using the inputs held across it
  task automatic model_edge();
    exp_t e;
    exp_t tmp;
    bit   keep;
    m_acc = 1'b0;
    if (!rst_n) begin
      mq.delete();
      m_ready = 1'b0;
      m_last  = RESET_EXP;
    end else if (flush) begin
      mq.delete();
      m_ready = 1'b1;
    end else begin
      m_acc = in_valid && m_ready;
      e = model_expect(in_instr, in_rs1, in_rs2, in_imm, keep);
      if (mq.size() > 0 && out_ready) tmp = mq.pop_front();
      if (m_acc && keep) mq.push_back(e);
      m_ready = (mq.size() < 2);
    end
    if (mq.size() > 0) m_last = mq[0];
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send1(input logic [31:0] instr, input logic [63:0] rs1,
                       input logic [63:0] rs2, input logic [63:0] imm);
    in_valid = 1'b1;
    in_instr = instr;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
    step();
    in_valid = 1'b0;
  endtask

  // Compare process: every cycle, the DUT must match the model
  always @(negedge clk) begin : compare
    exp_t h;
    if (chk_en) begin
      h = (mq.size() > 0) ? mq[0] : m_last;
      chk("in_ready",    64'(in_ready),    64'(m_ready));
      chk("out_valid",   64'(out_valid),   64'(mq.size() > 0));
      chk("out_a",       out_a,            h.a);
      chk("out_b",       out_b,            h.b);
      chk("out_ctrl",    64'(out_ctrl),    64'(h.ctrl));
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      chk("out_illegal", 64'(out_illegal), 64'(h.ill));
`else
      chk("out_illegal", 64'(out_illegal), 64'd0);
`endif
    end
  end

  logic [31:0] prog [12] = '{
    32'h002081B3, 32'h402081B3, 32'h0020F1B3, 32'h0020E1B3,
    32'h0FF0F193, 32'h0000007F, 32'h00508193, 32'h0000B183,
    32'h0020B423, 32'h00209063, 32'h002091B3, 32'h00208063
  };

  initial begin : stim
    exp_t   pin;
    bit     keep;
    in_t    it;
    in_t    drop;
    logic [63:0] got[$];
    logic [15:0] vpat;
    logic [15:0] rpat;
    int     idx;
    bit     done;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0; in_rs1 = 64'h0; in_rs2 = 64'h0; in_imm = 64'h0;
    m_ready = 1'b0; m_last = RESET_EXP;

    // Pin the model against hand-decoded instructions
    pin = model_expect(32'h002081B3, 64'd5, 64'd7, 64'd99, keep);
    chk("model_add", {pin.b, 62'd0, pin.ctrl}, {64'd7, 64'd2});
    pin = model_expect(32'h0FF0F193, 64'd1, 64'd2, 64'hFF, keep);
    chk("model_andi", {pin.b, 62'd0, pin.ctrl}, {64'hFF, 64'd0});
    pin = model_expect(32'h00209063, 64'd1, 64'd2, 64'd3, keep);
    chk("model_bne", {pin.b, 62'd0, pin.ctrl}, {64'd2, 64'd3});
    pin = model_expect(32'h0000007F, 64'd1, 64'd2, 64'd3, keep);
    chk("model_illegal", {pin.b, 63'd0, pin.ill}, {64'd0, 64'd1});

    // Reset
    step();
    chk_en = 1'b1;
    step();
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_ctrl",  64'(out_ctrl),  64'd2);
    rst_n = 1'b1;
    step();
    chk("release_in_ready", 64'(in_ready), 64'd1);

    // Single ops, out_ready high: one-cycle latency, one per cycle
    send1(32'h002081B3, 64'd5, 64'd7, 64'hDEAD);
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_ctrl",  64'(out_ctrl),  64'd2);
    chk("add_a",     out_a,          64'd5);
    chk("add_b",     out_b,          64'd7);
    send1(32'h402081B3, 64'h10, 64'h10, 64'hBEEF);
    chk("sub_ctrl",  64'(out_ctrl),  64'd3);
    chk("sub_b",     out_b,          64'h10);
    send1(32'h0FF0F193, 64'd3, 64'h1234, 64'hFF);
    chk("andi_ctrl", 64'(out_ctrl),  64'd0);
    chk("andi_b",    out_b,          64'hFF);
    send1(32'h0F00E193, 64'd3, 64'h1234, 64'hF0);
    chk("ori_ctrl",  64'(out_ctrl),  64'd1);
    send1(32'h00508193, 64'd8, 64'd1, 64'd5);
    send1(32'h0000B183, 64'h1000, 64'd1, 64'hFFFF_FFFF_FFFF_FFF8);
    send1(32'h0020B423, 64'h2000, 64'd1, 64'd8);
    send1(32'h00208063, 64'd4, 64'd4, 64'd16);
    send1(32'h00209063, 64'd4, 64'd5, 64'd16);

    // Illegal encodings
    send1(32'h0000007F, 64'd9, 64'd10, 64'd11);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    chk("illegal_valid", 64'(out_valid),   64'd1);
    chk("illegal_flag",  64'(out_illegal), 64'd1);
    chk("illegal_b",     out_b,            64'd0);
`else
    chk("illegal_valid", 64'(out_valid),   64'd0);
    chk("illegal_ready", 64'(in_ready),    64'd1);
`endif
    send1(32'h002091B3, 64'd1, 64'd2, 64'd3);
    send1(32'h0020C063, 64'd1, 64'd2, 64'd3);
    step();

    // Stall: four ops, out_ready low for three cycles
    for (int i = 0; i < 4; i++) begin
      it.instr = 32'h002081B3; it.rs1 = 64'(i + 1); it.rs2 = 64'(10 * i); it.imm = 64'd0;
      pend.push_back(it);
    end
    got.delete();
    done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (pend.size() == 0 && mq.size() == 0) begin
        done = 1'b1;
        break;
      end
      out_ready = (c >= 3);
      if (out_valid && out_ready) got.push_back(out_a);
      in_valid = (pend.size() > 0);
      if (in_valid) begin
        in_instr = pend[0].instr; in_rs1 = pend[0].rs1;
        in_rs2 = pend[0].rs2; in_imm = pend[0].imm;
      end
      step();
      if (m_acc) drop = pend.pop_front();
      if (c == 1) chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stall_timeout", 64'(done), 64'd1);
    chk("stall_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("stall_order", got[i], 64'(i + 1));

    // Flush while full, with a concurrent offer
    out_ready = 1'b0;
    send1(32'h002081B3, 64'h21, 64'd1, 64'd0);
    send1(32'h002081B3, 64'h22, 64'd1, 64'd0);
    flush = 1'b1;
    send1(32'h002081B3, 64'h99, 64'd1, 64'd0);
    flush = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready),  64'd1);
    out_ready = 1'b1;
    step();
    step();
    chk("flush_no_emit", 64'(out_valid), 64'd0);

    // Reset mid-stall
    out_ready = 1'b0;
    send1(32'h0020E1B3, 64'h31, 64'd1, 64'd0);
    send1(32'h0020E1B3, 64'h32, 64'd1, 64'd0);
    rst_n = 1'b0;
    out_ready = 1'b1;
    step();
    chk("midrst_ctrl",  64'(out_ctrl),  64'd2);
    chk("midrst_a",     out_a,          64'd0);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("midrst_no_emit", 64'(out_valid), 64'd0);

    // Mixed traffic over irregular valid/ready patterns
    vpat = 16'b1101_1111_0110_1011;
    rpat = 16'b1011_0011_1110_0101;
    idx = 0;
    for (int c = 0; c < 80; c++) begin
      if (idx >= 12 && mq.size() == 0) break;
      out_ready = rpat[c % 16];
      in_valid  = vpat[c % 16] && (idx < 12);
      if (idx < 12) begin
        in_instr = prog[idx];
        in_rs1   = 64'h100 + 64'(idx);
        in_rs2   = 64'h200 + 64'(idx);
        in_imm   = 64'h300 + 64'(idx);
      end
      step();
      if (m_acc) idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("mixed_all_accepted", 64'(idx), 64'd12);
    step();
    step();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
